// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes the fetched instruction and reads operands with write-back bypass.
// Tracks in-flight destinations in a busy scoreboard and issues through a one-entry output register.
module id_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]      opcode;
  logic [REGW-1:0] rd, rs1, rs2;
  logic            use_rs1, use_rs2, use_rd, illegal;
  logic [XLEN-1:0] imm;
  logic            rd_we;
  logic            byp1, byp2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            raw1, raw2, waw, stall;
  logic            accept;
  logic            flush_clr;
  logic [NREG-1:1] busy, busy_nxt;
  logic [NREG-1:0] busy_full;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  // Register-use class and immediate format by opcode
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        use_rd = 1'b1;
        imm    = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        imm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign rd_we = use_rd && (rd != '0);

  // Same-cycle write-back forwarding into the operand capture
  assign byp1    = wb_we && (wb_rd != '0) && (wb_rd == rs1);
  assign byp2    = wb_we && (wb_rd != '0) && (wb_rd == rs2);
  assign rs1_val = byp1 ? wb_data : rf_rd1;
  assign rs2_val = byp2 ? wb_data : rf_rd2;

  assign busy_full = {busy, 1'b0};
  assign raw1  = use_rs1 && busy_full[rs1] && !byp1;
  assign raw2  = use_rs2 && busy_full[rs2] && !byp2;
  assign waw   = rd_we && busy_full[rd] && !(wb_we && (wb_rd == rd));
  assign stall = raw1 || raw2 || waw;

  assign in_ready  = !flush && !stall && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign flush_clr = flush && out_valid && out_rd_we;

  // Scoreboard update; a set on the same bit overrides any clear
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy_nxt[i] = (accept && rd_we && (rd == REGW'(i))) ||
                    (busy[i] && !((wb_we && (wb_rd == REGW'(i))) ||
                                  (flush_clr && (out_rd == REGW'(i)))));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_rs1_val  <= rs1_val;
        out_rs2_val  <= rs2_val;
        out_imm      <= imm;
        out_rd       <= rd;
        out_rd_we    <= rd_we;
        out_opcode   <= opcode;
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_illegal  <= illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: expected issue payloads are queued when an instruction
// is offered for acceptance and checked when it appears in the output register.
module tb_id_issue_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  int   n_asrt = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  // Register-file stub with fixed contents, x0 reads 0
  function automatic logic [31:0] rf_model(input logic [4:0] a);
    case (a)
      5'd1:    return 32'h0000_0100;
      5'd2:    return 32'h0000_ABCD;
      default: return 32'h0;
    endcase
  endfunction

  assign rf_rd1 = rf_model(rf_a1);
  assign rf_rd2 = rf_model(rf_a2);

  id_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .rf_a1        (rf_a1),
    .rf_a2        (rf_a2),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_imm      (out_imm),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_illegal  (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [4:0] rd, input logic rd_we,
                      input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                      input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.rd_we = rd_we;
    e.op = op; e.f3 = f3; e.f7b5 = f7b5; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic cmp_out(input exp_t e, input string tag);
    chk({tag, ".valid"},   32'(out_valid), 32'd1);
    chk({tag, ".pc"},      out_pc, e.pc);
    chk({tag, ".rs1"},     out_rs1_val, e.rs1);
    chk({tag, ".rs2"},     out_rs2_val, e.rs2);
    chk({tag, ".imm"},     out_imm, e.imm);
    chk({tag, ".rd_we"},   32'(out_rd_we), 32'(e.rd_we));
    if (e.rd_we) chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
    chk({tag, ".opcode"},  32'(out_opcode), 32'(e.op));
    chk({tag, ".funct3"},  32'(out_funct3), 32'(e.f3));
    chk({tag, ".f7b5"},    32'(out_funct7b5), 32'(e.f7b5));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask

  task automatic check_pop(input string tag);
    n_asrt++;
    assert (sb.size() != 0)
    else begin
      n_fail++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      cmp_out(cur, tag);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset asserted between clock edges
    #2 rst = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_pc",    out_pc, 32'd0);
    chk("rst.out_imm",   out_imm, 32'd0);
    chk("rst.out_rs1",   out_rs1_val, 32'd0);
    chk("rst.out_rd",    32'(out_rd), 32'd0);
    chk("rst.busy",      32'(dut.busy), 32'd0);

    // addi x5,x0,7 on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0070_0293, 32'h0000_1000);
    #1 chk("addi.in_ready", 32'(in_ready), 32'd1);
    push(32'h1000, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1, 7'h13, 3'd0, 1'b0, 1'b0);
    step();
    check_pop("addi");
    chk("addi.busy5", 32'(dut.busy[5]), 32'd1);

    // add x6,x5,x5: RAW stall, then released by write-back bypass
    drive(1'b1, 32'h0052_8333, 32'h0000_1004);
    #1 chk("raw.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("raw.out_valid", 32'(out_valid), 32'd0);
    chk("raw.busy5", 32'(dut.busy[5]), 32'd1);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h7;
    #1 chk("byp.in_ready", 32'(in_ready), 32'd1);
    push(32'h1004, 32'h7, 32'h7, 32'h0, 5'd6, 1'b1, 7'h33, 3'd0, 1'b0, 1'b0);
    step();
    wb_we = 1'b0;
    check_pop("byp");
    chk("byp.busy5", 32'(dut.busy[5]), 32'd0);
    chk("byp.busy6", 32'(dut.busy[6]), 32'd1);

    // Backpressure hold for three cycles, then lui x7,0x12345 loads
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_53B7, 32'h0000_1008);
    #1 chk("hold.in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_out(cur, $sformatf("hold%0d", i));
      chk($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("lui.in_ready", 32'(in_ready), 32'd1);
    push(32'h1008, 32'h0, 32'h0, 32'h1234_5000, 5'd7, 1'b1, 7'h37, 3'd5, 1'b0, 1'b0);
    step();
    check_pop("lui");
    chk("lui.busy7", 32'(dut.busy[7]), 32'd1);

    // addi x9,x1,16 into the output register, then flushed
    drive(1'b1, 32'h0100_8493, 32'h0000_100C);
    #1 chk("addi9.in_ready", 32'(in_ready), 32'd1);
    push(32'h100C, 32'h100, 32'h0, 32'h10, 5'd9, 1'b1, 7'h13, 3'd0, 1'b0, 1'b0);
    step();
    check_pop("addi9");
    chk("addi9.busy9", 32'(dut.busy[9]), 32'd1);
    flush = 1'b1; out_ready = 1'b0;
    drive(1'b1, 32'h0010_0513, 32'h0000_1010);
    #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.busy9", 32'(dut.busy[9]), 32'd0);
    chk("flush.busy10", 32'(dut.busy[10]), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    #1 chk("addi10.in_ready", 32'(in_ready), 32'd1);
    push(32'h1010, 32'h0, 32'h100, 32'h1, 5'd10, 1'b1, 7'h13, 3'd0, 1'b0, 1'b0);
    step();
    check_pop("addi10");
    chk("addi10.busy10", 32'(dut.busy[10]), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idleflush.busy10", 32'(dut.busy[10]), 32'd1);
    chk("idleflush.out_valid", 32'(out_valid), 32'd0);

    // sw x2,-4(x1) and beq x1,x2,-8
    drive(1'b1, 32'hFE20_AE23, 32'h0000_1014);
    #1 chk("sw.in_ready", 32'(in_ready), 32'd1);
    push(32'h1014, 32'h100, 32'hABCD, 32'hFFFF_FFFC, 5'd28, 1'b0, 7'h23, 3'd2, 1'b1, 1'b0);
    step();
    check_pop("sw");
    drive(1'b1, 32'hFE20_8CE3, 32'h0000_1018);
    #1 chk("beq.in_ready", 32'(in_ready), 32'd1);
    push(32'h1018, 32'h100, 32'hABCD, 32'hFFFF_FFF8, 5'd25, 1'b0, 7'h63, 3'd0, 1'b1, 1'b0);
    step();
    check_pop("beq");
    chk("beq.imm_bit0", 32'(out_imm[0]), 32'd0);

    // add x11,x6,x7 stalls on busy x6; reset lands mid-stall
    out_ready = 1'b0;
    drive(1'b1, 32'h0073_05B3, 32'h0000_101C);
    #1 chk("stall.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("stall.out_valid", 32'(out_valid), 32'd1);
    chk("stall.busy6", 32'(dut.busy[6]), 32'd1);
    #2 rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.busy", 32'(dut.busy), 32'd0);
    chk("midrst.out_imm", out_imm, 32'd0);
    chk("midrst.out_pc", out_pc, 32'd0);

    // Illegal opcode 0x7F
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_2000);
    #1 chk("ill.in_ready", 32'(in_ready), 32'd1);
    push(32'h2000, 32'h0, 32'h0, 32'h0, 5'd31, 1'b0, 7'h7F, 3'd7, 1'b1, 1'b1);
    step();
    check_pop("ill");
    chk("ill.busy", 32'(dut.busy), 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("end.out_valid", 32'(out_valid), 32'd0);
    chk("end.sb_left", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
